// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit bus controller.
// Holds the FSM state encoding, RV32I load/store funct3 codes, the
// byte-enable generator and the load lane extraction/extension function.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte enables for a store of the size encoded in funct3[1:0] at byte offset off.
  function automatic logic [3:0] be_gen(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      F3_B[1:0]: be_gen = 4'b0001 << off;
      F3_H[1:0]: be_gen = 4'b0011 << {off[1], 1'b0};
      default:   be_gen = 4'b1111;
    endcase
  endfunction

  // Pick the addressed byte/half lane out of a bus word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    load_extend = {{24{b[7]}}, b};
      F3_BU:   load_extend = {24'b0, b};
      F3_H:    load_extend = {{16{h[15]}}, h};
      F3_HU:   load_extend = {16'b0, h};
      default: load_extend = word;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational alignment logic for the load/store unit: access fault
// detection, store byte enables and lane replication, load extraction.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        mem_we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] bus_rdata,
  output logic        access_fault,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] ld_data
);

  logic misalign;
  logic bad_f3;

  // Flag misaligned halfword/word accesses and funct3 codes with no defined load/store.
  always_comb begin
    misalign = ((funct3[1:0] == F3_H[1:0]) && addr_lo[0]) ||
               ((funct3[1:0] == F3_W[1:0]) && (addr_lo != 2'b00));
    if (mem_we)
      bad_f3 = funct3[2];
    else
      bad_f3 = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    access_fault = misalign | bad_f3;
  end

  // Replicate the store data across every lane the slave could pick it up from.
  always_comb begin
    be = be_gen(funct3, addr_lo);
    case (funct3[1:0])
      F3_B[1:0]: wdata_rep = {4{wdata[7:0]}};
      F3_H[1:0]: wdata_rep = {2{wdata[15:0]}};
      default:   wdata_rep = wdata;
    endcase
  end

  // Extract the load lane using the funct3/offset latched when the request started.
  always_comb begin
    ld_data = load_extend(ld_funct3, ld_off, bus_rdata);
  end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Load/store unit bus controller: turns the core's single-cycle memory
// request into a valid/grant/rvalid bus transaction and stalls the core
// until it completes. Optional macro LSU_TIMEOUT_EN adds a bus wait limit
// that ends a stuck transaction with a fault.
module lsu_bus_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              fault,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata
);

  lsu_state_e  state;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_off;
  logic [31:0] rdata_q;
  logic        access_fault;
  logic        req_fault;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] ld_data;

  lsu_align u_align (
    .mem_we       (mem_we),
    .funct3       (funct3),
    .addr_lo      (addr[1:0]),
    .wdata        (wdata),
    .ld_funct3    (ld_funct3),
    .ld_off       (ld_off),
    .bus_rdata    (bus_rdata),
    .access_fault (access_fault),
    .be           (be_next),
    .wdata_rep    (wdata_next),
    .ld_data      (ld_data)
  );

  assign req_fault = (state == IDLE) && mem_req && access_fault;
  assign stall     = ((state == IDLE) && mem_req && !access_fault) ||
                     (state == REQ) || (state == WAIT);
  // A faulting access must hand the write-back mux zero, not stale data.
  assign rdata     = fault ? '0 : rdata_q;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_fault;
  logic             timeout_hit;

  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign fault       = req_fault | timeout_fault;
`else
  assign fault = req_fault;

  // TIMEOUT_CYCLES has no effect unless the timeout build is selected.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  // Transaction FSM; every bus-facing output is registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      rdata_q   <= '0;
      ld_funct3 <= '0;
      ld_off    <= '0;
`ifdef LSU_TIMEOUT_EN
      wait_cnt      <= '0;
      timeout_fault <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (mem_req && !access_fault) begin
            bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
            bus_be    <= be_next;
            bus_wdata <= wdata_next;
            bus_we    <= mem_we;
            ld_funct3 <= funct3;
            ld_off    <= addr[1:0];
            bus_req   <= 1'b1;
            state     <= REQ;
`ifdef LSU_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
          end
        end
        REQ: begin
          if (bus_gnt) begin
            bus_req <= 1'b0;
            if (bus_we) begin
              state <= DONE;
            end else if (bus_rvalid) begin
              rdata_q <= ld_data;
              state   <= DONE;
            end else begin
              state <= WAIT;
            end
          end
`ifdef LSU_TIMEOUT_EN
          wait_cnt <= wait_cnt + 1'b1;
          if (timeout_hit && !(bus_gnt && (bus_we || bus_rvalid))) begin
            bus_req       <= 1'b0;
            rdata_q       <= '0;
            timeout_fault <= 1'b1;
            state         <= DONE;
          end
`endif
        end
        WAIT: begin
          if (bus_rvalid) begin
            rdata_q <= ld_data;
            state   <= DONE;
          end
`ifdef LSU_TIMEOUT_EN
          wait_cnt <= wait_cnt + 1'b1;
          if (timeout_hit && !bus_rvalid) begin
            rdata_q       <= '0;
            timeout_fault <= 1'b1;
            state         <= DONE;
          end
`endif
        end
        DONE: begin
          state <= IDLE;
`ifdef LSU_TIMEOUT_EN
          timeout_fault <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Self-checking bench for lsu_bus_ctrl: directed scenarios plus randomized
// loads/stores with random bus wait states, checked against a behavioural
// model of the RV32I load/store rules.
module tb_lsu_bus_ctrl;

`ifdef LSU_TIMEOUT_EN
  localparam int TB_TIMEOUT = 8;
`else
  localparam int TB_TIMEOUT = 255;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic        mem_we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        fault;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] model_rdata = '0;

  lsu_bus_ctrl #(.ADDR_W(32), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .stall      (stall),
    .fault      (fault),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: RV32I load/store rules expressed arithmetically.
  function automatic bit exp_fault(input bit we, input logic [2:0] f3, input logic [31:0] a);
    int size;
    size = int'(f3) % 4;
    if (we && f3 >= 3'd4) return 1'b1;
    if (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
    if (size == 1 && (a % 2) != 0) return 1'b1;
    if (size == 2 && (a % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
    case (int'(f3) % 4)
      0:       return 4'(1 << (a % 4));
      1:       return 4'(3 << (a & 32'd2));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (int'(f3) % 4)
      0:       return (wd & 32'hFF) * 32'h01010101;
      1:       return (wd & 32'hFFFF) * 32'h00010001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] word);
    logic [31:0] raw;
    logic [31:0] v;
    raw = word >> ((a % 4) * 8);
    case (f3)
      3'd0: begin v = raw & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256;   return v; end
      3'd4: return raw & 32'hFF;
      3'd1: begin v = raw & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; return v; end
      3'd5: return raw & 32'hFFFF;
      default: return word;
    endcase
  endfunction

  function automatic int exp_stalls(input bit we, input int gnt_dly, input int rv_dly);
    return 1 + (gnt_dly + 1) + (we ? 0 : rv_dly);
  endfunction

  // Runs one core request against a bus slave with the given wait states and reports what it saw.
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, input int gnt_dly, input int rv_dly,
                               input logic [31:0] rd, input bit rv_noise,
                               output int stalls, output logic [31:0] o_addr, output logic [3:0] o_be,
                               output logic [31:0] o_wdata, output logic o_we,
                               output logic [31:0] o_rdata, output logic o_fault,
                               output bit finished, output bit steady);
    int  req_cycles;
    int  wait_cycles;
    bit  granted;
    req_cycles = 0; wait_cycles = 0; granted = 0;
    stalls = 0; finished = 0; steady = 1;
    o_addr = '0; o_be = '0; o_wdata = '0; o_we = 1'b0; o_rdata = '0; o_fault = 1'b0;
    @(negedge clk);
    mem_req = 1'b1; mem_we = we; funct3 = f3; addr = a; wdata = wd; bus_rdata = rd;
    for (int c = 0; c < 300; c++) begin
      #1;
      if (!stall) begin
        o_rdata = rdata; o_fault = fault; finished = 1;
        break;
      end
      stalls++;
      if (bus_req) begin
        if (req_cycles == 0) begin
          o_addr = bus_addr; o_be = bus_be; o_wdata = bus_wdata; o_we = bus_we;
        end else if (bus_addr !== o_addr || bus_be !== o_be || bus_wdata !== o_wdata || bus_we !== o_we) begin
          steady = 0;
        end
        bus_gnt = (req_cycles == gnt_dly);
        bus_rvalid = bus_gnt ? (!we && rv_dly == 0) : rv_noise;
        if (bus_gnt) granted = 1;
        req_cycles++;
      end else if (granted) begin
        wait_cycles++;
        bus_rvalid = (wait_cycles == rv_dly);
      end
      @(negedge clk);
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
    end
    mem_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_req = 1'b0; mem_we = 1'b0; funct3 = '0; addr = '0; wdata = '0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    compared++;
    if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata, rdata, fault} !== 103'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got req=%b we=%b addr=%h be=%b wd=%h rdata=%h fault=%b, required all zero",
               bus_req, bus_we, bus_addr, bus_be, bus_wdata, rdata, fault);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    compared++;
    if (stall !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_stall: got %b required 0", stall);
    end
    model_rdata = '0;
  endtask

  task automatic test_store_word();
    int st; logic [31:0] oa, ow, ord; logic [3:0] ob; logic owe, of; bit fin, stdy;
    applyStimulus(1'b1, 3'b010, 32'h104, 32'hA1B2C3D4, 1, 0, 32'h0, 1'b0,
                  st, oa, ob, ow, owe, ord, of, fin, stdy);
    compared++;
    if (!fin || st != 3 || !stdy) begin
      mismatched++;
      $display("[TB] FAIL sw_latency: got finished=%0d stalls=%0d steady=%0d, required 1/3/1", fin, st, stdy);
    end
    compared++;
    if ({oa, ob, ow, owe} !== {32'h104, 4'b1111, 32'hA1B2C3D4, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL sw_bus: got addr=%h be=%b wd=%h we=%b, required 104/1111/a1b2c3d4/1", oa, ob, ow, owe);
    end
    compared++;
    if (of !== 1'b0 || ord !== model_rdata) begin
      mismatched++;
      $display("[TB] FAIL sw_done: got fault=%b rdata=%h, required 0/%h", of, ord, model_rdata);
    end
  endtask

  task automatic test_store_byte();
    int st; logic [31:0] oa, ow, ord; logic [3:0] ob; logic owe, of; bit fin, stdy;
    applyStimulus(1'b1, 3'b000, 32'h103, 32'h000000EE, 0, 0, 32'h0, 1'b0,
                  st, oa, ob, ow, owe, ord, of, fin, stdy);
    compared++;
    if (!fin || st != 2) begin
      mismatched++;
      $display("[TB] FAIL sb_latency: got finished=%0d stalls=%0d, required 1/2", fin, st);
    end
    compared++;
    if ({oa, ob, ow} !== {32'h100, 4'b1000, 32'hEEEEEEEE}) begin
      mismatched++;
      $display("[TB] FAIL sb_bus: got addr=%h be=%b wd=%h, required 100/1000/eeeeeeee", oa, ob, ow);
    end
  endtask

  task automatic test_load_sign();
    int st; logic [31:0] oa, ow, ord; logic [3:0] ob; logic owe, of; bit fin, stdy;
    applyStimulus(1'b0, 3'b000, 32'h102, 32'h0, 0, 3, 32'h12F45678, 1'b0,
                  st, oa, ob, ow, owe, ord, of, fin, stdy);
    compared++;
    if (!fin || st != 5 || ord !== 32'hFFFFFFF4 || of !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL lb_sign: got finished=%0d stalls=%0d rdata=%h fault=%b, required 1/5/fffffff4/0",
               fin, st, ord, of);
    end
    applyStimulus(1'b0, 3'b100, 32'h102, 32'h0, 0, 3, 32'h12F45678, 1'b0,
                  st, oa, ob, ow, owe, ord, of, fin, stdy);
    compared++;
    if (!fin || ord !== 32'h000000F4 || oa !== 32'h100) begin
      mismatched++;
      $display("[TB] FAIL lbu_zero: got finished=%0d rdata=%h addr=%h, required 1/000000f4/100", fin, ord, oa);
    end
    repeat (2) @(negedge clk);
    #1;
    compared++;
    if (rdata !== 32'h000000F4) begin
      mismatched++;
      $display("[TB] FAIL rdata_hold: got %h required 000000f4", rdata);
    end
    model_rdata = 32'h000000F4;
  endtask

  task automatic test_fault();
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; funct3 = 3'b001; addr = 32'h201;
    #1;
    compared++;
    if ({fault, stall, rdata} !== {1'b1, 1'b0, 32'h0}) begin
      mismatched++;
      $display("[TB] FAIL lh_misalign: got fault=%b stall=%b rdata=%h, required 1/0/0", fault, stall, rdata);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      compared++;
      if (bus_req !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL fault_no_bus: got bus_req=%b required 0", bus_req);
      end
    end
    funct3 = 3'b011; addr = 32'h200;
    #1;
    compared++;
    if (fault !== 1'b1 || stall !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL load_f3_011: got fault=%b stall=%b, required 1/0", fault, stall);
    end
    mem_we = 1'b1; funct3 = 3'b100;
    #1;
    compared++;
    if (fault !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL store_f3_100: got fault=%b required 1", fault);
    end
    funct3 = 3'b010; addr = 32'h102;
    #1;
    compared++;
    if (fault !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL sw_misalign: got fault=%b required 1", fault);
    end
    mem_req = 1'b0;
    #1;
    compared++;
    if (fault !== 1'b0 || rdata !== model_rdata) begin
      mismatched++;
      $display("[TB] FAIL fault_release: got fault=%b rdata=%h, required 0/%h", fault, rdata, model_rdata);
    end
  endtask

  task automatic test_reset_midtxn();
    int st; logic [31:0] oa, ow, ord; logic [3:0] ob; logic owe, of; bit fin, stdy;
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; funct3 = 3'b000; addr = 32'h101; bus_rdata = 32'h0;
    @(negedge clk);
    bus_gnt = 1'b1; bus_rvalid = 1'b0;
    @(negedge clk);
    bus_gnt = 1'b0;
    #1;
    compared++;
    if (bus_req !== 1'b0 || stall !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL wait_entry: got bus_req=%b stall=%b, required 0/1", bus_req, stall);
    end
    #1 reset = 1'b1;
    #1;
    compared++;
    if (bus_req !== 1'b0 || rdata !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_in_wait: got bus_req=%b rdata=%h, required 0/0", bus_req, rdata);
    end
    mem_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_rdata = '0;
    applyStimulus(1'b0, 3'b010, 32'h8, 32'h0, 0, 0, 32'hCAFEBABE, 1'b0,
                  st, oa, ob, ow, owe, ord, of, fin, stdy);
    compared++;
    if (!fin || st != 2 || ord !== 32'hCAFEBABE || oa !== 32'h8) begin
      mismatched++;
      $display("[TB] FAIL lw_after_reset: got finished=%0d stalls=%0d rdata=%h addr=%h, required 1/2/cafebabe/8",
               fin, st, ord, oa);
    end
    model_rdata = 32'hCAFEBABE;
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    int st; logic [31:0] oa, ow, ord; logic [3:0] ob; logic owe, of; bit fin, stdy;
    applyStimulus(1'b0, 3'b010, 32'h40, 32'h0, 100000, 0, 32'h55555555, 1'b0,
                  st, oa, ob, ow, owe, ord, of, fin, stdy);
    compared++;
    if (!fin || st != 1 + TB_TIMEOUT || of !== 1'b1 || ord !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL timeout: got finished=%0d stalls=%0d fault=%b rdata=%h, required 1/%0d/1/0",
               fin, st, of, ord, 1 + TB_TIMEOUT);
    end
    model_rdata = '0;
  endtask
`endif

  task automatic test_random();
    int st, gd, rv; logic [31:0] oa, ow, ord, a, wd, rd; logic [3:0] ob; logic owe, of;
    bit fin, stdy, we, illegal, noise; logic [2:0] f3;
    for (int n = 0; n < 60; n++) begin
      we = 1'($urandom_range(0, 1));
      illegal = ($urandom_range(0, 7) == 0);
      if (we) begin
        f3 = illegal ? 3'(4 + $urandom_range(0, 3)) : 3'($urandom_range(0, 2));
      end else if (illegal) begin
        case ($urandom_range(0, 2))
          0: f3 = 3'd3;
          1: f3 = 3'd6;
          default: f3 = 3'd7;
        endcase
      end else begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0;
          1: f3 = 3'd1;
          2: f3 = 3'd2;
          3: f3 = 3'd4;
          default: f3 = 3'd5;
        endcase
      end
      a = $urandom;
      if ($urandom_range(0, 9) < 7) begin
        if (int'(f3) % 4 == 1) a = a - (a % 2);
        if (int'(f3) % 4 == 2) a = a - (a % 4);
      end
      wd = $urandom; rd = $urandom;
      gd = $urandom_range(0, 3); rv = $urandom_range(0, 3);
      noise = 1'($urandom_range(0, 1));
      applyStimulus(we, f3, a, wd, gd, rv, rd, noise, st, oa, ob, ow, owe, ord, of, fin, stdy);
      compared++;
      if (exp_fault(we, f3, a)) begin
        if (!fin || st != 0 || of !== 1'b1 || ord !== 32'h0) begin
          mismatched++;
          $display("[TB] FAIL rand_fault[%0d]: we=%b f3=%0d a=%h got stalls=%0d fault=%b rdata=%h, required 0/1/0",
                   n, we, f3, a, st, of, ord);
        end
        @(negedge clk);
        #1;
        compared++;
        if (bus_req !== 1'b0) begin
          mismatched++;
          $display("[TB] FAIL rand_fault_bus[%0d]: got bus_req=%b required 0", n, bus_req);
        end
      end else begin
        if (!we) model_rdata = exp_load(f3, a, rd);
        if (!fin || st != exp_stalls(we, gd, rv) || !stdy || of !== 1'b0 || ord !== model_rdata) begin
          mismatched++;
          $display("[TB] FAIL rand_txn[%0d]: we=%b f3=%0d a=%h got stalls=%0d steady=%0d fault=%b rdata=%h, required %0d/1/0/%h",
                   n, we, f3, a, st, stdy, of, ord, exp_stalls(we, gd, rv), model_rdata);
        end
        compared++;
        if (oa !== (a & ~32'h3) || owe !== we || (we && (ob !== exp_be(f3, a) || ow !== exp_wdata(f3, wd)))) begin
          mismatched++;
          $display("[TB] FAIL rand_bus[%0d]: got addr=%h we=%b be=%b wd=%h, required %h/%b/%b/%h",
                   n, oa, owe, ob, ow, a & ~32'h3, we, exp_be(f3, a), exp_wdata(f3, wd));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_store_byte();
    test_load_sign();
    test_fault();
    test_reset_midtxn();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
